nhci_spi_engine: RTL and testbench



---
 rtl/nhci_spi_pkg.sv | 23 ++
 rtl/nhci_spi_engine_if.sv | 42 ++++
 rtl/nhci_sync_fifo.sv | 67 ++++++
 rtl/nhci_spi_engine.sv | 162 ++++++++++++++++
 tb/tb_nhci_spi_engine.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nhci_spi_pkg.sv
// Shared types and constants for the NHCI SPI master.
//   spi_state_e : engine FSM states
//   DEF_DEPTH   : default FIFO depth (entries, power of two, >= 2)
//   DEF_CLK_DIV : default SCLK half-period in clk_26 cycles (>= 1)
//   level_w()   : width of a FIFO occupancy count, $clog2(depth)+1
package nhci_spi_pkg;

  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_CLK_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } spi_state_e;

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nhci_spi_engine_if.sv
// Host/pin bundle of the NHCI SPI master.
//   master : register decoder (push/pop/flags) plus the card's MISO driver
//   slave  : nhci_spi_engine
// Host side : wr_en, wr_data, rd_en, rd_data, ss_req, tx_full, rx_empty,
//             tx_level, rx_level, tx_ovf, ovf_clr, busy
// Pin side  : SS (active low), SCLK (idle low), MOSI, MISO
interface nhci_spi_engine_if #(
  parameter int unsigned DEPTH = nhci_spi_pkg::DEF_DEPTH
) ();

  localparam int unsigned LW = nhci_spi_pkg::level_w(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          ss_req;
  logic          tx_full;
  logic          rx_empty;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          tx_ovf;
  logic          ovf_clr;
  logic          busy;
  logic          SS;
  logic          SCLK;
  logic          MOSI;
  logic          MISO;

  modport master (
    output wr_en, wr_data, rd_en, ss_req, ovf_clr, MISO,
    input  rd_data, tx_full, rx_empty, tx_level, rx_level, tx_ovf, busy,
           SS, SCLK, MOSI
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ss_req, ovf_clr, MISO,
    output rd_data, tx_full, rx_empty, tx_level, rx_level, tx_ovf, busy,
           SS, SCLK, MOSI
  );

endinterface

// File: rtl/nhci_sync_fifo.sv
// Byte-wide synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   wr_en_i    : push wr_data_i; dropped while full
//   rd_en_i    : pop head; ignored while empty
//   rd_data_o  : current head (0 after reset)
//   full_o, empty_o, level_o : registered occupancy flags/count
module nhci_sync_fifo
  import nhci_spi_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      rd_en_i,
  output logic [7:0]                rd_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [level_w(DEPTH)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_wr_c, do_rd_c;

  // Qualified push/pop and next occupancy
  always_comb begin
    do_wr_c = wr_en_i & ~full_q;
    do_rd_c = rd_en_i & ~empty_q;
    cnt_d   = cnt_q;
    if (do_wr_c && !do_rd_c)      cnt_d = cnt_q + LW'(1);
    else if (!do_wr_c && do_rd_c) cnt_d = cnt_q - LW'(1);
  end

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr_c) begin
        mem_q[wp_q] <= wr_data_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (do_rd_c) rp_q <= rp_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == LW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign rd_data_o = mem_q[rp_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = cnt_q;

endmodule

// File: rtl/nhci_spi_engine.sv
// Byte-oriented SPI master (mode 0, MSB first) with TX/RX FIFOs.
//   clk_26  : system clock
//   RESET_N : async active-low reset; aborts any byte and empties both FIFOs
//   bus     : nhci_spi_engine_if.slave (host push/pop/flags and SPI pins)
// Optional build macro NHCI_SPI_LOOPBACK_EN: the shifter samples its own
// MOSI and the MISO pin is ignored.
module nhci_spi_engine
  import nhci_spi_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk_26,
  input  logic              RESET_N,
  nhci_spi_engine_if.slave  bus
);

  localparam int unsigned DW = $clog2(CLK_DIV) + 1;

  spi_state_e    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          ss_q, ss_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic          tx_empty, rx_full;
  logic [7:0]    tx_head;
  logic          tx_pop_c, rx_push_c, sample_bit_c;

  assign tx_pop_c  = (state_q == ST_LOAD);
  assign rx_push_c = (state_q == ST_DONE);

`ifdef NHCI_SPI_LOOPBACK_EN
  assign sample_bit_c = mosi_q;
`else
  assign sample_bit_c = bus.MISO;
`endif

  nhci_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk_26),
    .rst_n     (RESET_N),
    .wr_en_i   (bus.wr_en),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (tx_pop_c),
    .rd_data_o (tx_head),
    .full_o    (bus.tx_full),
    .empty_o   (tx_empty),
    .level_o   (bus.tx_level)
  );

  nhci_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk_26),
    .rst_n     (RESET_N),
    .wr_en_i   (rx_push_c),
    .wr_data_i (rx_sh_q),
    .rd_en_i   (bus.rd_en),
    .rd_data_o (bus.rd_data),
    .full_o    (rx_full),
    .empty_o   (bus.rx_empty),
    .level_o   (bus.rx_level)
  );

  // Next-state, shifter and pin logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        // RX must have room before a byte starts, so RX can never overrun
        if (!tx_empty && !rx_full && bus.ss_req) begin
          state_d = ST_LOAD;
          mosi_d  = tx_head[7];
        end
      end
      ST_LOAD: begin
        tx_sh_d = tx_head;
        div_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], sample_bit_c};
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            mosi_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            // Rotate so the next bit sits at [7] and drives MOSI on the fall
            tx_sh_d = {tx_sh_q[6:0], tx_sh_q[7]};
            mosi_d  = tx_sh_q[6];
            bit_d   = bit_q + 3'd1;
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    // Dropping ss_req mid-byte keeps SS low until the byte completes
    ss_d   = ~(bus.ss_req | busy_d);
    ovf_d  = (ovf_q & ~bus.ovf_clr) | (bus.wr_en & bus.tx_full);
  end

  // State and output registers
  always_ff @(posedge clk_26 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.SCLK   = sclk_q;
  assign bus.MOSI   = mosi_q;
  assign bus.SS     = ss_q;
  assign bus.busy   = busy_q;
  assign bus.tx_ovf = ovf_q;

endmodule

// File: tb/tb_nhci_spi_engine.sv
// Directed bench for nhci_spi_engine (DEPTH=8, CLK_DIV=2).
// MISO is either looped from MOSI or driven from a per-byte reply pattern.
module tb_nhci_spi_engine;
  import nhci_spi_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CLK_DIV = 2;

  logic clk_26  = 1'b0;
  logic RESET_N = 1'b0;
  always #5 clk_26 = ~clk_26;

  nhci_spi_engine_if #(.DEPTH(DEPTH)) bus ();

  nhci_spi_engine #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk_26  (clk_26),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  logic loop_mode;
  logic miso_drv;
  assign bus.MISO = loop_mode ? bus.MOSI : miso_drv;

  int checks = 0;
  int errors = 0;

  // Per-cycle trace filled by observe()
  int         rises, first_rise, last_rise, min_gap, max_gap;
  logic [7:0] mosi_bits;
  logic       busy_at [0:79];
  logic       ss_at   [0:79];
  logic       rxe_at  [0:79];
  logic [3:0] rxl_at  [0:79];
  logic [7:0] rd_at   [0:79];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_26);
    #1;
  endtask

  task automatic apply_reset();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0; bus.ss_req = 1'b0;
    RESET_N = 1'b0;
    #3;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en = 1'b1; bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  // Runs ncyc cycles (cycle 1 = first tick), tracing pins and flags.
  // wr_en is released after every tick so a pending push lands exactly once.
  task automatic observe(input int ncyc, input logic [7:0] pat);
    logic prev;
    int   gap;
    prev = bus.SCLK; rises = 0; first_rise = -1; last_rise = 0;
    min_gap = 1000; max_gap = 0; mosi_bits = '0; miso_drv = pat[7];
    busy_at[0] = bus.busy; ss_at[0] = bus.SS; rxe_at[0] = bus.rx_empty;
    rxl_at[0] = bus.rx_level; rd_at[0] = bus.rd_data;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      bus.wr_en = 1'b0;
      if (bus.SCLK && !prev) begin
        if (rises == 0) first_rise = c;
        else begin
          gap = c - last_rise;
          if (gap < min_gap) min_gap = gap;
          if (gap > max_gap) max_gap = gap;
        end
        last_rise = c;
        rises++;
        mosi_bits = {mosi_bits[6:0], bus.MOSI};
        miso_drv  = (rises < 8) ? pat[3'(7 - rises)] : 1'b0;
      end
      prev = bus.SCLK;
      busy_at[c] = bus.busy; ss_at[c] = bus.SS; rxe_at[c] = bus.rx_empty;
      rxl_at[c] = bus.rx_level; rd_at[c] = bus.rd_data;
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0; bus.ss_req = 1'b0;
    bus.wr_data = '0; loop_mode = 1'b1; miso_drv = 1'b0;
    RESET_N = 1'b0;
    #22;
    checks++; if (bus.SS !== 1'b1) begin errors++; $display("FAIL reset_ss got=%b exp=1", bus.SS); end
    checks++; if (bus.SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", bus.SCLK); end
    checks++; if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", bus.MOSI); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full got=%b exp=0", bus.tx_full); end
    checks++; if (bus.rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty got=%b exp=1", bus.rx_empty); end
    checks++; if (bus.tx_level !== 4'd0) begin errors++; $display("FAIL reset_tx_level got=%0d exp=0", bus.tx_level); end
    checks++; if (bus.rx_level !== 4'd0) begin errors++; $display("FAIL reset_rx_level got=%0d exp=0", bus.rx_level); end
    checks++; if (bus.tx_ovf !== 1'b0) begin errors++; $display("FAIL reset_tx_ovf got=%b exp=0", bus.tx_ovf); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    RESET_N = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_loopback_byte();
    logic b0;
    loop_mode = 1'b1;
    bus.ss_req = 1'b1;
    tick(); tick();
    push(8'hA5);
    b0 = bus.busy;
    observe(35, 8'h00);
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL lb_busy_c0 got=%b exp=0", b0); end
    checks++; if (ss_at[1] !== 1'b0) begin errors++; $display("FAIL lb_ss_c1 got=%b exp=0", ss_at[1]); end
    checks++; if (busy_at[1] !== 1'b1) begin errors++; $display("FAIL lb_busy_c1 got=%b exp=1", busy_at[1]); end
    checks++; if (first_rise != 4) begin errors++; $display("FAIL lb_first_rise got=%0d exp=4", first_rise); end
    checks++; if (rises != 8) begin errors++; $display("FAIL lb_rises got=%0d exp=8", rises); end
    checks++; if (min_gap != 4 || max_gap != 4) begin errors++; $display("FAIL lb_pitch got=%0d..%0d exp=4", min_gap, max_gap); end
    checks++; if (mosi_bits !== 8'hA5) begin errors++; $display("FAIL lb_mosi got=%h exp=a5", mosi_bits); end
    checks++; if (busy_at[34] !== 1'b1) begin errors++; $display("FAIL lb_busy_c34 got=%b exp=1", busy_at[34]); end
    checks++; if (rxe_at[34] !== 1'b1) begin errors++; $display("FAIL lb_rx_empty_c34 got=%b exp=1", rxe_at[34]); end
    checks++; if (rxe_at[35] !== 1'b0) begin errors++; $display("FAIL lb_rx_empty_c35 got=%b exp=0", rxe_at[35]); end
    checks++; if (busy_at[35] !== 1'b0) begin errors++; $display("FAIL lb_busy_c35 got=%b exp=0", busy_at[35]); end
    checks++; if (rd_at[35] !== 8'hA5) begin errors++; $display("FAIL lb_rd_data got=%h exp=a5", rd_at[35]); end
    pop();
    checks++; if (bus.rx_empty !== 1'b1) begin errors++; $display("FAIL lb_rx_empty_after_pop got=%b exp=1", bus.rx_empty); end
  endtask

  task automatic test_pin_byte();
    logic [7:0] exp_rx;
`ifdef NHCI_SPI_LOOPBACK_EN
    exp_rx = 8'hC3;
`else
    exp_rx = 8'h3C;
`endif
    loop_mode = 1'b0;
    push(8'hC3);
    observe(40, 8'h3C);
    checks++; if (mosi_bits !== 8'hC3) begin errors++; $display("FAIL pin_mosi_seq got=%h exp=c3", mosi_bits); end
    checks++; if (bus.rd_data !== exp_rx) begin errors++; $display("FAIL pin_rd_data got=%h exp=%h", bus.rd_data, exp_rx); end
    checks++; if (bus.rx_level !== 4'd1) begin errors++; $display("FAIL pin_rx_level got=%0d exp=1", bus.rx_level); end
    pop();
    loop_mode = 1'b1;
  endtask

  task automatic test_overflow();
    logic ss_all_hi;
    bus.ss_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.tx_full !== 1'b1) begin errors++; $display("FAIL ovf_tx_full got=%b exp=1", bus.tx_full); end
    checks++; if (bus.tx_level !== 4'd8) begin errors++; $display("FAIL ovf_tx_level got=%0d exp=8", bus.tx_level); end
    checks++; if (bus.tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.tx_ovf); end
    observe(12, 8'h00);
    ss_all_hi = 1'b1;
    for (int c = 0; c <= 12; c++) if (ss_at[c] !== 1'b1) ss_all_hi = 1'b0;
    checks++; if (ss_all_hi !== 1'b1) begin errors++; $display("FAIL ovf_ss_idle got=%b exp=1", ss_all_hi); end
    checks++; if (rises != 0) begin errors++; $display("FAIL ovf_sclk_rises got=%0d exp=0", rises); end
    bus.ovf_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    bus.ovf_clr = 1'b0; bus.wr_en = 1'b0;
    checks++; if (bus.tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_push got=%b exp=1", bus.tx_ovf); end
    checks++; if (bus.tx_level !== 4'd8) begin errors++; $display("FAIL ovf_level_hold got=%0d exp=8", bus.tx_level); end
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    checks++; if (bus.tx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", bus.tx_ovf); end
    pop();
    checks++; if (bus.rx_level !== 4'd0 || bus.rx_empty !== 1'b1) begin errors++; $display("FAIL pop_empty got=%0d/%b exp=0/1", bus.rx_level, bus.rx_empty); end
  endtask

  task automatic test_rx_full();
    int   guard;
    logic sclk_seen;
    apply_reset();
    loop_mode = 1'b1;
    bus.ss_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (bus.tx_full && guard < 200) begin tick(); guard++; end
      push(8'h10 + 8'(i));
    end
    guard = 0;
    while (bus.rx_level != 4'd8 && guard < 800) begin tick(); guard++; end
    checks++; if (bus.rx_level !== 4'd8) begin errors++; $display("FAIL rxfull_wait got=%0d exp=8", bus.rx_level); end
    sclk_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin tick(); if (bus.SCLK) sclk_seen = 1'b1; end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rxfull_busy got=%b exp=0", bus.busy); end
    checks++; if (sclk_seen !== 1'b0) begin errors++; $display("FAIL rxfull_sclk got=%b exp=0", sclk_seen); end
    checks++; if (bus.SS !== 1'b0) begin errors++; $display("FAIL rxfull_ss got=%b exp=0", bus.SS); end
    checks++; if (bus.tx_level !== 4'd2) begin errors++; $display("FAIL rxfull_tx_level got=%0d exp=2", bus.tx_level); end
    checks++; if (bus.rd_data !== 8'h10) begin errors++; $display("FAIL rxfull_head got=%h exp=10", bus.rd_data); end
    pop();
    checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL rxfull_next_head got=%h exp=11", bus.rd_data); end
    tick(); tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rxfull_restart got=%b exp=1", bus.busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    loop_mode = 1'b1;
    bus.ss_req = 1'b1;
    tick();
    push(8'h5A);
    bus.wr_en = 1'b1; bus.wr_data = 8'h96;
    observe(72, 8'h00);
    checks++; if (busy_at[35] !== 1'b0) begin errors++; $display("FAIL b2b_gap_c35 got=%b exp=0", busy_at[35]); end
    checks++; if (busy_at[36] !== 1'b1) begin errors++; $display("FAIL b2b_load_c36 got=%b exp=1", busy_at[36]); end
    checks++; if (rxl_at[69] !== 4'd1) begin errors++; $display("FAIL b2b_rxl_c69 got=%0d exp=1", rxl_at[69]); end
    checks++; if (rxl_at[70] !== 4'd2) begin errors++; $display("FAIL b2b_rxl_c70 got=%0d exp=2", rxl_at[70]); end
    checks++; if (rises != 16) begin errors++; $display("FAIL b2b_rises got=%0d exp=16", rises); end
    checks++; if (mosi_bits !== 8'h96) begin errors++; $display("FAIL b2b_mosi2 got=%h exp=96", mosi_bits); end
    checks++; if (rd_at[70] !== 8'h5A) begin errors++; $display("FAIL b2b_head got=%h exp=5a", rd_at[70]); end
  endtask

  task automatic test_ss_drop();
    logic sclk_late;
    apply_reset();
    loop_mode = 1'b1;
    bus.ss_req = 1'b1;
    tick();
    push(8'h11);
    bus.wr_en = 1'b1; bus.wr_data = 8'h22;
    tick();
    bus.wr_data = 8'h33;
    tick();
    bus.wr_en = 1'b0;
    sclk_late = 1'b0;
    for (int c = 3; c <= 45; c++) begin
      tick();
      if (c == 10) bus.ss_req = 1'b0;
      busy_at[c] = bus.busy; ss_at[c] = bus.SS;
      if (c >= 35 && bus.SCLK) sclk_late = 1'b1;
    end
    checks++; if (busy_at[34] !== 1'b1 || ss_at[34] !== 1'b0) begin errors++; $display("FAIL ssdrop_done got=%b/%b exp=1/0", busy_at[34], ss_at[34]); end
    checks++; if (ss_at[35] !== 1'b1) begin errors++; $display("FAIL ssdrop_ss_rise got=%b exp=1", ss_at[35]); end
    checks++; if (busy_at[45] !== 1'b0 || sclk_late !== 1'b0) begin errors++; $display("FAIL ssdrop_no_restart got=%b/%b exp=0/0", busy_at[45], sclk_late); end
    checks++; if (bus.tx_level !== 4'd2) begin errors++; $display("FAIL ssdrop_tx_level got=%0d exp=2", bus.tx_level); end
    checks++; if (bus.rx_level !== 4'd1 || bus.rd_data !== 8'h11) begin errors++; $display("FAIL ssdrop_rx got=%0d/%h exp=1/11", bus.rx_level, bus.rd_data); end
  endtask

  task automatic test_reset_mid();
    int guard;
    apply_reset();
    loop_mode = 1'b1;
    bus.ss_req = 1'b1;
    tick();
    push(8'hF0);
    push(8'h0F);
    guard = 0;
    while (!bus.SCLK && guard < 50) begin tick(); guard++; end
    checks++; if (bus.SCLK !== 1'b1 || bus.MOSI !== 1'b1) begin errors++; $display("FAIL rstmid_setup got=%b/%b exp=1/1", bus.SCLK, bus.MOSI); end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++; if (bus.SCLK !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got=%b exp=0", bus.SCLK); end
    checks++; if (bus.SS !== 1'b1) begin errors++; $display("FAIL rstmid_ss got=%b exp=1", bus.SS); end
    checks++; if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL rstmid_mosi got=%b exp=0", bus.MOSI); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_level !== 4'd0 || bus.rx_level !== 4'd0 || bus.rx_empty !== 1'b1) begin errors++; $display("FAIL rstmid_fifos got=%0d/%0d/%b exp=0/0/1", bus.tx_level, bus.rx_level, bus.rx_empty); end
    bus.ss_req = 1'b0;
    #3;
    RESET_N = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_loopback_byte();
    test_pin_byte();
    test_overflow();
    test_rx_full();
    test_back_to_back();
    test_ss_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
